instr_fetch: RTL

Instruction fetch stage directly upstream of the instruction decoder in the MIPS core. It holds the program counter, fetches one instruction word per instruction over a variable-latency req/ack port to instruction memory, and presents the word stable on `instr` to the decoder. It computes the next PC from the decoder's `dobranch`/`dojump` results and keeps a retired-instruction counter.

---
 rtl/instr_fetch.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction fetch stage.
// Holds the program counter and fetches one instruction word per instruction
// over a variable-latency req/ack memory port. The word is held stable on
// instr for the decoder. The next PC is taken from the decoder's
// dobranch/dojump results, and the stage counts retired instructions.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   imem_req     fetch request, high exactly while fetching
//   imem_addr    byte address of the word being fetched (equals pc)
//   imem_ack     memory returns valid data this cycle
//   imem_rdata   instruction word from memory
//   instr        registered instruction word for the decoder
//   instr_valid  instr is valid and being executed
//   pc           address of the current instruction
//   advance      datapath completes the current instruction at this edge
//   dobranch     take the PC-relative branch
//   dojump       take the absolute jump (has priority over dobranch)
//   retired      count of completed instructions (wraps)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        advance,
  input  logic        dobranch,
  input  logic        dojump,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state;

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] branch_off;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] next_pc;

  // Next-PC candidates, all derived from registered pc and instr only.
  assign pc4           = pc + XLEN'(4);
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc4 + branch_off;
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};

  // Jump wins over branch when both are asserted.
  always_comb begin
    next_pc = pc4;
    if (dojump) begin
      next_pc = jump_target;
    end else if (dobranch) begin
      next_pc = branch_target;
    end
  end

  // The address bus is the PC itself, so it stays stable until ack.
  assign imem_addr = pc;

  // Fetch/hold sequencer with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
      pc          <= RESET_PC;
      instr       <= '0;
      retired     <= '0;
    end else begin
      case (state)
        FETCH: begin
          // rdata is only looked at when the request is acknowledged.
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (advance) begin
            pc          <= next_pc;
            retired     <= retired + XLEN'(1);
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
